// File: rtl/half_adder_pkg.sv
// Shared definitions for the registered half adder.
// Lane-count limits, default sizes and the per-lane result bundle.
package half_adder_pkg;

   localparam int WIDTH_DEF = 1;
   localparam int CNT_W_DEF = 16;
   localparam int WIDTH_MAX = 64;

   typedef struct packed {
      logic sum;
      logic carry;
   } ha_res_t;

   function automatic ha_res_t ha_eval(input logic a, input logic b);
      ha_res_t r;
      r.sum   = a ^ b;
      r.carry = a & b;
      return r;
   endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-bit combinational half-adder cell.
// Shared leaf used by wider adders built on top of it.
module half_adder_cell
   import half_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   ha_res_t res;

   // Evaluate the cell truth table
   always_comb begin
      res   = ha_eval(a, b);
      sum   = res.sum;
      carry = res.carry;
   end

endmodule

// File: rtl/half_adder.sv
// Registered bit-parallel half adder with a saturating
// carry-event counter; every output comes straight from a flop.
module half_adder
   import half_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clear,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic             carry_any,
   output logic [CNT_W-1:0] carry_cnt
);

   if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("half_adder: WIDTH out of range");
   end

   if (CNT_W < 1) begin : g_bad_cnt
      $error("half_adder: CNT_W must be positive");
   end

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] nxt_sum;
   logic [WIDTH-1:0] nxt_carry;
   logic             nxt_any;
   logic             cnt_hit;
   logic             cnt_sat;

   // Independent lanes: no carry ever crosses a lane boundary
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_cell u_cell (
         .a     (a[i]),
         .b     (b[i]),
         .sum   (nxt_sum[i]),
         .carry (nxt_carry[i])
      );
   end

   // Carry-event detection for the accepted input
   always_comb begin
      nxt_any = |nxt_carry;
      cnt_hit = in_valid & nxt_any;
      cnt_sat = (carry_cnt == CNT_MAX);
   end

   // Result registers; data holds while no input is offered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         carry     <= '0;
         carry_any <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum       <= nxt_sum;
            carry     <= nxt_carry;
            carry_any <= nxt_any;
         end
      end
   end

   // Saturating carry counter; clear beats a same-cycle increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_cnt <= '0;
      end else if (clear) begin
         carry_cnt <= '0;
      end else if (cnt_hit && !cnt_sat) begin
         carry_cnt <= carry_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder (16 lanes, 4-bit counter)
// against an arithmetic lane model kept in the bench.
module tb_half_adder;

   localparam int W  = 16;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          clear;
   logic          out_valid;
   logic [W-1:0]  sum;
   logic [W-1:0]  carry;
   logic          carry_any;
   logic [CW-1:0] carry_cnt;

   half_adder #(.WIDTH(W), .CNT_W(CW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .clear     (clear),
      .out_valid (out_valid),
      .sum       (sum),
      .carry     (carry),
      .carry_any (carry_any),
      .carry_cnt (carry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic         m_valid;
   logic [W-1:0] m_sum;
   logic [W-1:0] m_carry;
   logic         m_any;
   int           m_cnt;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
      check({tag, ".sum"},   64'(sum),       64'(m_sum));
      check({tag, ".carry"}, 64'(carry),     64'(m_carry));
      check({tag, ".any"},   64'(carry_any), 64'(m_any));
      check({tag, ".cnt"},   64'(carry_cnt), 64'(m_cnt));
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_sum   = '0;
      m_carry = '0;
      m_any   = 1'b0;
      m_cnt   = 0;
   endtask

   // Behaviour of one rising edge, from the lane arithmetic a+b
   task automatic model_edge(input logic v, input logic [W-1:0] ma,
                             input logic [W-1:0] mb, input logic clr);
      int s;
      int ncar;
      ncar = 0;
      if (v) begin
         for (int i = 0; i < W; i++) begin
            s = int'(ma[i]) + int'(mb[i]);
            m_sum[i]   = (s % 2) != 0;
            m_carry[i] = (s / 2) != 0;
            ncar += s / 2;
         end
         m_any = ncar > 0;
      end
      m_valid = v;
      if (clr) m_cnt = 0;
      else if (v && ncar > 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
   endtask

   // Drive now, take the next edge, check 1 time unit later
   task automatic apply_now(input logic v, input logic [W-1:0] ta,
                            input logic [W-1:0] tb, input logic clr,
                            input string tag);
      in_valid = v;
      a        = ta;
      b        = tb;
      clear    = clr;
      @(posedge clk);
      model_edge(v, ta, tb, clr);
      #1;
      check_all(tag);
   endtask

   task automatic step(input logic v, input logic [W-1:0] ta,
                       input logic [W-1:0] tb, input logic clr,
                       input string tag);
      @(negedge clk);
      apply_now(v, ta, tb, clr, tag);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rv;
      logic         rc;

      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      clear    = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check_all("reset");

      @(negedge clk);
      rst = 1'b0;

      // Single-lane truth table on lane 0
      step(1'b1, 16'h0000, 16'h0000, 1'b0, "tt00");
      step(1'b1, 16'h0000, 16'h0001, 1'b0, "tt01");
      step(1'b1, 16'h0001, 16'h0000, 1'b0, "tt10");
      step(1'b1, 16'h0001, 16'h0001, 1'b0, "tt11");
      check("tt11.cnt_one", 64'(carry_cnt), 64'd1);
      check("tt11.carry_one", 64'(carry), 64'h1);

      // Byte-wide pattern
      step(1'b1, 16'h00F0, 16'h00CC, 1'b0, "byte");
      check("byte.sum_k", 64'(sum), 64'h3C);
      check("byte.carry_k", 64'(carry), 64'hC0);

      // Idle cycles hold data and count
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, "idle");
      end
      check("idle.sum_k", 64'(sum), 64'h3C);

      // Saturation then clear on a counting cycle
      step(1'b0, 16'h0000, 16'h0000, 1'b1, "clr0");
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "sat");
      end
      check("sat.cnt_max", 64'(carry_cnt), 64'd15);
      step(1'b1, 16'h8000, 16'h8000, 1'b1, "clrwin");
      check("clrwin.cnt_zero", 64'(carry_cnt), 64'd0);
      step(1'b1, 16'h0101, 16'h0100, 1'b0, "post_clr");

      // Asynchronous reset between edges, input in flight
      @(negedge clk);
      in_valid = 1'b1;
      a        = 16'hFFFF;
      b        = 16'h0F0F;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("arst_async");
      @(posedge clk);
      #1;
      check_all("arst_hold");
      @(negedge clk);
      rst = 1'b0;
      apply_now(1'b1, 16'h1234, 16'h5678, 1'b0, "arst_first");
      step(1'b0, 16'h0000, 16'h0000, 1'b0, "arst_idle");

      // Randomised traffic
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         rc = ($urandom_range(0, 31) == 0);
         step(rv, ra, rb, rc, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
